// File: rtl/apb_bank_pkg.sv
// Shared types and decode helpers for the APB multi-bank completer.
// Holds the FSM state encoding, the response codes and the address-error decode used by apb_multi_slave_bank.
package apb_bank_pkg;

   typedef enum logic {IDLE, ACCESS} state_t;

   localparam logic OKAY = 1'b0;
   localparam logic ERR  = 1'b1;

   function automatic int unsigned idx_width(input int unsigned depth);
      return $clog2(depth);
   endfunction

   // Error when the select is not one-hot, the address is misaligned,
   // or any byte-address bit above the bank's word range is set.
   function automatic logic xfer_err(input logic sel_onehot, input logic [63:0] addr,
                                     input int unsigned addr_w, input int unsigned idx_w);
      logic [63:0] mask;
      mask = ((64'd1 << addr_w) - 64'd1) & ~((64'd1 << (idx_w + 2)) - 64'd1);
      return !sel_onehot || (addr[1:0] != 2'b00) || ((addr & mask) != 64'd0);
   endfunction

endpackage

// File: rtl/apb_multi_slave_bank_regfile.sv
// One register bank: DEPTH x DATA_W flops with synchronous clear,
// a single write port and an asynchronous read port sharing one index.
module apb_slv_regfile
   import apb_bank_pkg::*;
#(
   parameter int unsigned DEPTH  = 16,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned IDX_W  = 4
) (
   input  logic              hclk,
   input  logic              hreset,
   input  logic              we,
   input  logic [IDX_W-1:0]  idx,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge hclk) begin
      if (hreset) begin
         for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (we) begin
         mem[idx] <= wdata;
      end
   end

   assign rdata = mem[idx];

endmodule

// File: rtl/apb_multi_slave_bank.sv
// APB completer with NUM_SLV one-hot-selected register banks, phase checking and error decode.
// Define APB_WAIT_EN to insert WAIT_CYC wait states per access; otherwise every access completes at once.
module apb_multi_slave_bank
   import apb_bank_pkg::*;
#(
   parameter int unsigned NUM_SLV  = 3,
   parameter int unsigned DEPTH    = 16,
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned ADDR_W   = 32,
   parameter int unsigned WAIT_CYC = 2
) (
   input  logic               hclk,
   input  logic               hreset,
   input  logic [NUM_SLV-1:0] pselx,
   input  logic               penable,
   input  logic               pwrite,
   input  logic [ADDR_W-1:0]  paddr,
   input  logic [DATA_W-1:0]  pwdata,
   output logic [DATA_W-1:0]  prdata,
   output logic               pready,
   output logic               pslverr,
   output logic               proto_err,
   output logic               xfer_done
);

   localparam int unsigned IDX_W = idx_width(DEPTH);

   state_t             state;
   logic [NUM_SLV-1:0] sel_q;
   logic [ADDR_W-1:0]  addr_q;
   logic               pwrite_q;
   logic [DATA_W-1:0]  wdata_q;
   logic               access_ok;
   logic               wait_done;
   logic               err;
   logic [IDX_W-1:0]   idx;
   logic [DATA_W-1:0]  bank_rdata [NUM_SLV];
   logic [DATA_W-1:0]  rd_or;

   assign idx       = addr_q[2 +: IDX_W];
   assign err       = xfer_err($onehot(sel_q), 64'(addr_q), ADDR_W, IDX_W);
   assign access_ok = (state == ACCESS) && penable && (pselx == sel_q);
   assign pready    = access_ok && wait_done;
   assign pslverr   = (pready && err) ? ERR : OKAY;
   assign xfer_done = pready;

`ifdef APB_WAIT_EN
   localparam int unsigned CNT_W = (WAIT_CYC > 0) ? $clog2(WAIT_CYC + 1) : 1;
   logic [CNT_W-1:0] wait_cnt;

   assign wait_done = (wait_cnt == CNT_W'(WAIT_CYC));

   always_ff @(posedge hclk) begin
      if (hreset || state == IDLE) wait_cnt <= '0;
      else if (access_ok && !wait_done) wait_cnt <= wait_cnt + 1'b1;
   end
`else
   assign wait_done = 1'b1;
`endif

   always_ff @(posedge hclk) begin
      if (hreset) begin
         state     <= IDLE;
         sel_q     <= '0;
         addr_q    <= '0;
         pwrite_q  <= 1'b0;
         wdata_q   <= '0;
         proto_err <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (pselx != '0) begin
                  if (!penable) begin
                     sel_q    <= pselx;
                     addr_q   <= paddr;
                     pwrite_q <= pwrite;
                     wdata_q  <= pwdata;
                     state    <= ACCESS;
                  end else begin
                     proto_err <= 1'b1;
                  end
               end
            end
            ACCESS: begin
               if (!access_ok) begin
                  proto_err <= 1'b1;
                  state     <= IDLE;
               end else if (wait_done) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   for (genvar g = 0; g < NUM_SLV; g++) begin : g_bank
      apb_slv_regfile #(
         .DEPTH  (DEPTH),
         .DATA_W (DATA_W),
         .IDX_W  (IDX_W)
      ) u_regfile (
         .hclk   (hclk),
         .hreset (hreset),
         .we     (pready && pwrite_q && !err && sel_q[g]),
         .idx    (idx),
         .wdata  (wdata_q),
         .rdata  (bank_rdata[g])
      );
   end

   // Error cases include non-one-hot selects, so the OR-mux is only trusted when err is clear.
   always_comb begin
      rd_or = '0;
      for (int unsigned i = 0; i < NUM_SLV; i++) begin
         if (sel_q[i]) rd_or = rd_or | bank_rdata[i];
      end
   end

   assign prdata = (pready && !pwrite_q && !err) ? rd_or : '0;

endmodule
